// File: rtl/axis_frame_split.sv
// axis_frame_split
// Splits one AXI4-Stream input frame into consecutive sub-frames on M_COUNT
// output ports. An optional leading tag (TAG_WIDTH bits, LSB word first) is
// stripped and presented on `tag`. Port k receives seg_len[k] words; the last
// port receives everything remaining up to input tlast.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}   input stream
//   m_axis_tdata  [M_COUNT*DW]     same word replicated on every lane
//   m_axis_t{valid,ready,last,user}[M_COUNT]  per-port handshake/sideband
//   seg_len [M_COUNT*LEN_WIDTH]    words per port 0..M_COUNT-2 (top lane unused)
//   tag, tag_valid                 captured tag and its one-cycle update pulse
//   busy                           a frame is in progress
//   error_short                    input ended before the last port was reached
module axis_frame_split #(
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_ENABLE = 1,
    parameter int TAG_WIDTH  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tuser,
    output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT-1:0]              m_axis_tvalid,
    input  logic [M_COUNT-1:0]              m_axis_tready,
    output logic [M_COUNT-1:0]              m_axis_tlast,
    output logic [M_COUNT-1:0]              m_axis_tuser,
    input  logic [M_COUNT*LEN_WIDTH-1:0]    seg_len,
    output logic [TAG_WIDTH-1:0]            tag,
    output logic                            tag_valid,
    output logic                            busy,
    output logic                            error_short
);
    localparam int TAG_WORDS = (TAG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PTR_W     = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
    localparam int PORT_W    = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(M_COUNT - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(TAG_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ_TAG, TRANSFER} state_t;

    state_t                          state_reg, state_next;
    logic [PORT_W-1:0]               port_sel_reg, port_sel_next;
    logic [LEN_WIDTH-1:0]            cnt_reg, cnt_next;
    logic [PTR_W-1:0]                ptr_reg, ptr_next;
    logic [TAG_WORDS*DATA_WIDTH-1:0] tag_acc_reg, tag_acc_next;
    logic [TAG_WIDTH-1:0]            tag_reg, tag_next;
    logic                            tag_valid_reg, tag_valid_next;
    logic                            error_short_reg, error_short_next;
    logic                            busy_reg;
    logic                            s_axis_tready_reg, s_axis_tready_next;
    logic                            out_ready_int_reg, out_ready_early;
    logic                            len_load;
    logic [LEN_WIDTH-1:0]            len_reg [M_COUNT];
    logic [LEN_WIDTH-1:0]            seg_len_arr [M_COUNT];
    logic [LEN_WIDTH-1:0]            len_sel_next;
    logic                            skip_next;

    // word handed from the FSM to the output datapath
    logic                            in_valid, in_last, in_user;
    logic [DATA_WIDTH-1:0]           in_data;
    logic [PORT_W-1:0]               in_port;

    // output register and skid register
    logic                            m_valid_reg, m_valid_next, m_last_reg, m_user_reg;
    logic [DATA_WIDTH-1:0]           m_data_reg;
    logic [PORT_W-1:0]               m_port_reg;
    logic                            temp_valid_reg, temp_valid_next, temp_last_reg, temp_user_reg;
    logic [DATA_WIDTH-1:0]           temp_data_reg;
    logic [PORT_W-1:0]               temp_port_reg;
    logic                            store_in_to_out, store_in_to_temp, store_temp_to_out;
    logic                            m_ready_sel;

    genvar gi;
    generate
        for (gi = 0; gi < M_COUNT; gi++) begin : g_lane
            logic lane_hit;
            assign seg_len_arr[gi] = seg_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign lane_hit = m_valid_reg && (m_port_reg == PORT_W'(gi));
            assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_data_reg;
            assign m_axis_tvalid[gi] = lane_hit;
            assign m_axis_tlast[gi]  = lane_hit && m_last_reg;
            assign m_axis_tuser[gi]  = lane_hit && m_user_reg;
        end
    endgenerate

    assign s_axis_tready = s_axis_tready_reg;
    assign tag           = tag_reg;
    assign tag_valid     = tag_valid_reg;
    assign busy          = busy_reg;
    assign error_short   = error_short_reg;

    // Frame FSM
    always_comb begin
        state_next       = state_reg;
        port_sel_next    = port_sel_reg;
        cnt_next         = cnt_reg;
        ptr_next         = ptr_reg;
        tag_acc_next     = tag_acc_reg;
        tag_next         = tag_reg;
        tag_valid_next   = 1'b0;
        error_short_next = 1'b0;
        len_load         = 1'b0;
        in_valid         = 1'b0;
        in_data          = s_axis_tdata;
        in_last          = 1'b0;
        in_user          = 1'b0;
        in_port          = port_sel_reg;

        case (state_reg)
            IDLE: begin
                if (s_axis_tvalid) begin
                    len_load      = 1'b1;
                    cnt_next      = '0;
                    ptr_next      = '0;
                    port_sel_next = '0;
                    state_next    = (TAG_ENABLE != 0) ? READ_TAG : TRANSFER;
                end
            end
            READ_TAG: begin
                if (s_axis_tvalid && s_axis_tready_reg) begin
                    for (int w = 0; w < TAG_WORDS; w++) begin
                        if (ptr_reg == PTR_W'(w))
                            tag_acc_next[w*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                    end
                    if (s_axis_tlast) begin
                        // truncated inside the tag: drop frame, keep old tag
                        error_short_next = 1'b1;
                        state_next       = IDLE;
                    end else if (ptr_reg == LAST_PTR) begin
                        tag_next       = tag_acc_next[TAG_WIDTH-1:0];
                        tag_valid_next = 1'b1;
                        port_sel_next  = '0;
                        cnt_next       = '0;
                        state_next     = TRANSFER;
                    end else begin
                        ptr_next = ptr_reg + PTR_W'(1);
                    end
                end
            end
            TRANSFER: begin
                if (port_sel_reg != LAST_PORT && len_reg[port_sel_reg] == '0) begin
                    // zero-length segment: advance without consuming a word
                    port_sel_next = port_sel_reg + PORT_W'(1);
                end else if (s_axis_tvalid && s_axis_tready_reg) begin
                    in_valid = 1'b1;
                    if (s_axis_tlast) begin
                        in_last    = 1'b1;
                        in_user    = s_axis_tuser;
                        state_next = IDLE;
                        if (port_sel_reg != LAST_PORT)
                            error_short_next = 1'b1;
                    end else if (port_sel_reg != LAST_PORT &&
                                 cnt_reg == len_reg[port_sel_reg] - LEN_WIDTH'(1)) begin
                        in_last       = 1'b1;
                        port_sel_next = port_sel_reg + PORT_W'(1);
                        cnt_next      = '0;
                    end else begin
                        // on the last port the count is unused, wrap is harmless
                        cnt_next = cnt_reg + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered input ready. Looks ahead at the port that will be selected
    // next cycle so a zero-length port is never offered a word; on the
    // IDLE->TRANSFER path the lengths are not latched yet, so use seg_len.
    always_comb begin
        len_sel_next    = (state_reg == IDLE) ? seg_len_arr[port_sel_next] : len_reg[port_sel_next];
        skip_next       = (port_sel_next != LAST_PORT) && (len_sel_next == '0);
        m_ready_sel     = m_axis_tready[m_port_reg];
        out_ready_early = !temp_valid_reg && (!m_valid_reg || m_ready_sel);
        s_axis_tready_next = (state_next == READ_TAG) ||
                             (state_next == TRANSFER && out_ready_early && !skip_next);
    end

    // Output datapath: the skid register only fills when a word was promised
    // by last cycle's ready but the output register did not drain.
    always_comb begin
        m_valid_next      = m_valid_reg;
        temp_valid_next   = temp_valid_reg;
        store_in_to_out   = 1'b0;
        store_in_to_temp  = 1'b0;
        store_temp_to_out = 1'b0;
        if (out_ready_int_reg) begin
            if (m_ready_sel || !m_valid_reg) begin
                m_valid_next    = in_valid;
                store_in_to_out = 1'b1;
            end else begin
                temp_valid_next  = in_valid;
                store_in_to_temp = 1'b1;
            end
        end else if (m_ready_sel) begin
            m_valid_next      = temp_valid_reg;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            port_sel_reg      <= '0;
            cnt_reg           <= '0;
            ptr_reg           <= '0;
            tag_acc_reg       <= '0;
            tag_reg           <= '0;
            tag_valid_reg     <= 1'b0;
            error_short_reg   <= 1'b0;
            busy_reg          <= 1'b0;
            s_axis_tready_reg <= 1'b0;
            out_ready_int_reg <= 1'b0;
            for (int i = 0; i < M_COUNT; i++) len_reg[i] <= '0;
            m_valid_reg       <= 1'b0;
            m_data_reg        <= '0;
            m_last_reg        <= 1'b0;
            m_user_reg        <= 1'b0;
            m_port_reg        <= '0;
            temp_valid_reg    <= 1'b0;
            temp_data_reg     <= '0;
            temp_last_reg     <= 1'b0;
            temp_user_reg     <= 1'b0;
            temp_port_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            port_sel_reg      <= port_sel_next;
            cnt_reg           <= cnt_next;
            ptr_reg           <= ptr_next;
            tag_acc_reg       <= tag_acc_next;
            tag_reg           <= tag_next;
            tag_valid_reg     <= tag_valid_next;
            error_short_reg   <= error_short_next;
            busy_reg          <= (state_next != IDLE);
            s_axis_tready_reg <= s_axis_tready_next;
            out_ready_int_reg <= out_ready_early;
            if (len_load) begin
                for (int i = 0; i < M_COUNT; i++) len_reg[i] <= seg_len_arr[i];
            end
            m_valid_reg    <= m_valid_next;
            temp_valid_reg <= temp_valid_next;
            if (store_in_to_out) begin
                m_data_reg <= in_data;
                m_last_reg <= in_last;
                m_user_reg <= in_user;
                m_port_reg <= in_port;
            end else if (store_temp_to_out) begin
                m_data_reg <= temp_data_reg;
                m_last_reg <= temp_last_reg;
                m_user_reg <= temp_user_reg;
                m_port_reg <= temp_port_reg;
            end
            if (store_in_to_temp) begin
                temp_data_reg <= in_data;
                temp_last_reg <= in_last;
                temp_user_reg <= in_user;
                temp_port_reg <= in_port;
            end
        end
    end
endmodule

// File: doc/axis_frame_split.md
# axis_frame_split

AXI4-Stream frame splitter: accepts one input frame, strips an optional leading tag of `TAG_WIDTH` bits, and distributes the remaining payload across `M_COUNT` output ports as consecutive sub-frames. Port k receives `seg_len[k]` words; the last port receives everything remaining up to input `tlast`. It is the receive-side counterpart of the frame joiner and sits after a link or FIFO to de-aggregate joined frames.

## Interface
- `M_COUNT`, 4: number of output ports.
- `DATA_WIDTH`, 8: data width in bits.
- `TAG_ENABLE`, 1: input frame begins with a tag to strip.
- `TAG_WIDTH`, 16: tag width in bits; occupies `TAG_WORDS = ceil(TAG_WIDTH/DATA_WIDTH)` words.
- `LEN_WIDTH`, 16: segment length field width.
- `clk` in 1: clock; the block uses this single clock.
- `rst` in 1: reset, synchronous and active-high.
- `s_axis_tdata` in `DATA_WIDTH`; `s_axis_tvalid` in 1; `s_axis_tready` out 1; `s_axis_tlast` in 1; `s_axis_tuser` in 1: input frame.
- `m_axis_tdata` out `M_COUNT*DATA_WIDTH`: the same word replicated on every lane.
- `m_axis_tvalid` out `M_COUNT`: at most one bit set.
- `m_axis_tready` in `M_COUNT`.
- `m_axis_tlast` out `M_COUNT`; `m_axis_tuser` out `M_COUNT`.
- `seg_len` in `M_COUNT*LEN_WIDTH`: words per segment for ports 0..M_COUNT-2. The lane for port M_COUNT-1 is ignored.
- `tag` out `TAG_WIDTH`: last captured tag.
- `tag_valid` out 1: one-cycle pulse when `tag` updates.
- `busy` out 1: high while a frame is in progress.
- `error_short` out 1: one-cycle pulse when input `tlast` arrives before the final port is reached.

## Operation
- States: IDLE, READ_TAG, TRANSFER.
- **IDLE**
  - `s_axis_tready` = 0.
  - On `s_axis_tvalid` (no word consumed), latch `seg_len` into internal length registers and clear the word counter and tag pointer.
  - Next state is READ_TAG if `TAG_ENABLE`, else TRANSFER with `port_sel` = 0.
- **READ_TAG**
  - `s_axis_tready` = 1, independent of the outputs.
  - Each accepted word fills tag bits `[ptr*DATA_WIDTH +: DATA_WIDTH]`. Word 0 is the least significant. Excess bits of the final word are discarded.
  - After word `TAG_WORDS-1`: `tag` updates and `tag_valid` pulses the following cycle; go to TRANSFER, `port_sel` = 0.
  - `tlast` on any tag word: frame dropped, `error_short` pulses, `tag` and `tag_valid` are unchanged, return to IDLE.
- **TRANSFER**
  - `s_axis_tready` = registered output-datapath ready for the port given by `port_sel`.
  - Skip rule: if `port_sel` < M_COUNT-1 and its latched length is 0, increment `port_sel` without consuming a word (one cycle per skipped port).
  - Each accepted word is forwarded to port `port_sel` and the counter increments.
  - Non-last port, counter reaches `len-1` and no input `tlast`: output `tlast`=1, `tuser`=0, then `port_sel`+1 and counter cleared.
  - Input `tlast` on a non-last port: output `tlast`=1, `tuser`=`s_axis_tuser`, `error_short` pulses, return to IDLE. Later ports receive no frame. This also applies when `tlast` coincides with the segment's final word.
  - Last port: words are forwarded until input `tlast`; output `tlast`=1, `tuser`=`s_axis_tuser`, return to IDLE.
  - Input `tuser` on non-`tlast` words is ignored.
- **Output datapath**: one output register plus one temp (skid) register, each holding data, last, user and port index. `m_axis_tvalid[p]` asserts only for the stored port index.
- `busy` = registered (next state ≠ IDLE).

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0, `tag`=0, `tag_valid`=0, `busy`=0, `error_short`=0. State returns to IDLE.
- Reset mid-frame discards all buffered words. No partial `tlast` is emitted.
- Latency: input acceptance to `m_axis_tvalid` is 1 cycle.
- Throughput: 1 word/cycle within a port while its `m_axis_tready` is held high.
- `s_axis_tready` is registered and derived from the early ready of the output datapath: (temp empty) AND (output empty OR selected `m_axis_tready`). This guarantees no loss when ready drops.
- Port switch: 0 idle cycles when the next length is nonzero, plus 1 cycle per zero-length port skipped.
- Frame start: 1 cycle in IDLE before the first word is accepted.
- Back-to-back frames: one IDLE cycle between the input `tlast` and the next frame's first word.
- `seg_len` is sampled only in IDLE; changes mid-frame have no effect.
- Output order is strictly preserved. No port ever has two frames interleaved.

## Test plan
- M_COUNT=4, DW=8, TAG_WIDTH=16, seg_len={2,3,1}. Input 0x34,0x12,A0..A8 with `tlast` on A8 -> `tag`=0x1234 with `tag_valid` pulsed; port0 A0,A1(last); port1 A2..A4(last); port2 A5(last); port3 A6..A8(last). `error_short`=0.
- Same stimulus, random `m_axis_tready` per port with 30% low and random input gaps -> identical per-port output sequences, no drops or duplicates, `m_axis_tvalid` one-hot at most.
- seg_len={2,0,1}, payload B0..B4 -> port0 B0,B1; port1 gets no frame; port2 B2; port3 B3,B4.
- seg_len={4,4,4}, payload C0..C5 with `tlast`+`tuser` on C5 -> port0 C0..C3; port1 C4,C5 with last=1, user=1; `error_short` pulses once; ports 2 and 3 idle.
- `tlast` on tag word 0 -> nothing output, `tag` unchanged, `error_short` pulse, `busy` low next cycle.
- Assert `rst` mid-segment on port1 -> the cycle after, all outputs are at reset values. The next frame splits correctly starting at port0.
